// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned FW_MODE_BITS = 2;

    typedef logic [FW_MODE_BITS-1:0] fw_mode_t;

    localparam fw_mode_t NO_FW  = 2'd0;
    localparam fw_mode_t FW_MEM = 2'd1;
    localparam fw_mode_t FW_WB  = 2'd2;

    // Winning pipeline-control condition, highest priority last in the list.
    typedef enum logic [1:0] {
        PriNone,
        PriHazard,
        PriBranch,
        PriFreeze
    } pri_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-bit scoreboard for variable-latency writers, with pending count and sticky error.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      long_issue,
    input  logic [REG_AW-1:0]         long_rd,
    input  logic                      long_done,
    input  logic [REG_AW-1:0]         long_done_rd,
    input  logic                      dmem_wait,
    output logic [(1 << REG_AW)-1:0]  busy,
    output logic                      sb_full,
    output logic                      sb_err
);

    localparam int unsigned NREGS  = 1 << REG_AW;
    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

    logic [NREGS-1:0]  busy_q, busy_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              err_q, err_d;
    logic              full, set_req, set_ok, clr_ok;

    // Next-state: clear first so a same-cycle set of the same register wins.
    always_comb begin
        full    = (pend_q == PEND_W'(MAX_PENDING));
        set_req = long_issue && (long_rd != '0) && !dmem_wait;
        set_ok  = set_req && !full;
        clr_ok  = long_done && busy_q[long_done_rd];

        busy_d = busy_q;
        if (clr_ok) busy_d[long_done_rd] = 1'b0;
        if (set_ok) busy_d[long_rd]      = 1'b1;

        pend_d = pend_q;
        case ({set_ok, clr_ok})
            2'b10:   pend_d = pend_q + PEND_W'(1);
            2'b01:   pend_d = pend_q - PEND_W'(1);
            default: pend_d = pend_q;
        endcase

        // Completion of an idle register or an issue into a full board are protocol errors.
        err_d = err_q | (long_done && !busy_q[long_done_rd]) | (set_req && full);
    end

    // State register; reset forgets all in-flight long ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign busy    = busy_q;
    assign sb_full = full;
    assign sb_err  = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/scoreboard stalls, branch flush,
// memory-wait freeze and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_AW-1:0]       rs1_dec,
    input  logic [REG_AW-1:0]       rs2_dec,
    input  logic [REG_AW-1:0]       rd_dec,
    input  logic                    reg_write_dec,
    input  logic                    long_dec,
    input  logic [REG_AW-1:0]       rs1_exe,
    input  logic [REG_AW-1:0]       rs2_exe,
    input  logic [REG_AW-1:0]       rd_exe,
    input  logic                    mem_read_exe,
    input  logic                    took_branch,
    input  logic                    long_issue,
    input  logic [REG_AW-1:0]       long_rd,
    input  logic                    long_done,
    input  logic [REG_AW-1:0]       long_done_rd,
    input  logic [REG_AW-1:0]       rd_mem,
    input  logic [REG_AW-1:0]       rd_wb,
    input  logic                    reg_write_mem,
    input  logic                    reg_write_wb,
    input  logic                    dmem_wait,
    output logic [FW_MODE_BITS-1:0] fwd_rs1_exe,
    output logic [FW_MODE_BITS-1:0] fwd_rs2_exe,
    output logic                    stall_fetch,
    output logic                    stall_dec,
    output logic                    stall_exe,
    output logic                    stall_mem,
    output logic                    flush_dec,
    output logic                    flush_exe,
    output logic                    sb_full,
    output logic                    sb_err,
    output logic [CNT_W-1:0]        stall_cycles
);

    localparam int unsigned NREGS = 1 << REG_AW;

    logic [NREGS-1:0] busy;
    logic             load_use, sb_hit, sb_stall;
    pri_e             pri;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    hazard_scoreboard #(
        .REG_AW      (REG_AW),
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .long_issue   (long_issue),
        .long_rd      (long_rd),
        .long_done    (long_done),
        .long_done_rd (long_done_rd),
        .dmem_wait    (dmem_wait),
        .busy         (busy),
        .sb_full      (sb_full),
        .sb_err       (sb_err)
    );

    function automatic fw_mode_t fw_sel(input logic [REG_AW-1:0] src,
                                        input logic [REG_AW-1:0] dst_mem,
                                        input logic              we_mem,
                                        input logic [REG_AW-1:0] dst_wb,
                                        input logic              we_wb);
        fw_mode_t sel;
        sel = NO_FW;
        if (src != '0) begin
            if (we_mem && (dst_mem == src))     sel = FW_MEM;
            else if (we_wb && (dst_wb == src))  sel = FW_WB;
        end
        return sel;
    endfunction

    // EXE operand forward selects; MEM is the younger producer so it wins over WB.
    always_comb begin
        fwd_rs1_exe = fw_sel(rs1_exe, rd_mem, reg_write_mem, rd_wb, reg_write_wb);
        fwd_rs2_exe = fw_sel(rs2_exe, rd_mem, reg_write_mem, rd_wb, reg_write_wb);
    end

    // Hazard detection and priority resolution.
    always_comb begin
        load_use = mem_read_exe && (rd_exe != '0) &&
                   ((rs1_dec == rd_exe) || (rs2_dec == rd_exe));
        sb_hit   = busy[rs1_dec] | busy[rs2_dec] | (reg_write_dec & busy[rd_dec]);
        sb_stall = sb_hit | (long_dec & sb_full);

        // A frozen EXE re-presents its branch, so the freeze must win over the flush.
        if (dmem_wait)                  pri = PriFreeze;
        else if (took_branch)           pri = PriBranch;
        else if (load_use || sb_stall)  pri = PriHazard;
        else                            pri = PriNone;
    end

    // Decode the winning condition into stall/flush enables.
    always_comb begin
        stall_fetch = 1'b0;
        stall_dec   = 1'b0;
        stall_exe   = 1'b0;
        stall_mem   = 1'b0;
        flush_dec   = 1'b0;
        flush_exe   = 1'b0;
        unique case (pri)
            PriFreeze: begin
                stall_fetch = 1'b1;
                stall_dec   = 1'b1;
                stall_exe   = 1'b1;
                stall_mem   = 1'b1;
            end
            PriBranch: begin
                flush_dec = 1'b1;
                flush_exe = 1'b1;
            end
            PriHazard: begin
                stall_fetch = 1'b1;
                stall_dec   = 1'b1;
                flush_exe   = 1'b1;
            end
            default: ;
        endcase
    end

    // Saturating stall-cycle counter next state.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_dec && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle model comparison plus directed literals.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned REG_AW      = 5;
    localparam int unsigned MAX_PENDING = 4;
    localparam int unsigned CNT_W       = 4;
    localparam int          NREGS       = 32;
    localparam int          CNT_MAX     = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] rs1_dec = '0, rs2_dec = '0, rd_dec = '0;
    logic reg_write_dec = 1'b0, long_dec = 1'b0;
    logic [4:0] rs1_exe = '0, rs2_exe = '0, rd_exe = '0;
    logic mem_read_exe = 1'b0, took_branch = 1'b0, long_issue = 1'b0, long_done = 1'b0;
    logic [4:0] long_rd = '0, long_done_rd = '0, rd_mem = '0, rd_wb = '0;
    logic reg_write_mem = 1'b0, reg_write_wb = 1'b0, dmem_wait = 1'b0;
    logic [1:0] fwd_rs1_exe, fwd_rs2_exe;
    logic stall_fetch, stall_dec, stall_exe, stall_mem, flush_dec, flush_exe;
    logic sb_full, sb_err;
    logic [CNT_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_AW      (REG_AW),
        .MAX_PENDING (MAX_PENDING),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rs1_dec       (rs1_dec),
        .rs2_dec       (rs2_dec),
        .rd_dec        (rd_dec),
        .reg_write_dec (reg_write_dec),
        .long_dec      (long_dec),
        .rs1_exe       (rs1_exe),
        .rs2_exe       (rs2_exe),
        .rd_exe        (rd_exe),
        .mem_read_exe  (mem_read_exe),
        .took_branch   (took_branch),
        .long_issue    (long_issue),
        .long_rd       (long_rd),
        .long_done     (long_done),
        .long_done_rd  (long_done_rd),
        .rd_mem        (rd_mem),
        .rd_wb         (rd_wb),
        .reg_write_mem (reg_write_mem),
        .reg_write_wb  (reg_write_wb),
        .dmem_wait     (dmem_wait),
        .fwd_rs1_exe   (fwd_rs1_exe),
        .fwd_rs2_exe   (fwd_rs2_exe),
        .stall_fetch   (stall_fetch),
        .stall_dec     (stall_dec),
        .stall_exe     (stall_exe),
        .stall_mem     (stall_mem),
        .flush_dec     (flush_dec),
        .flush_exe     (flush_exe),
        .sb_full       (sb_full),
        .sb_err        (sb_err),
        .stall_cycles  (stall_cycles)
    );

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    // Reference state: which registers await a long result, how many, error, counter.
    bit mbusy [NREGS];
    int mpend = 0;
    bit merr  = 1'b0;
    int mcnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fw_exp(input logic [4:0] src);
        if (src == 0) return int'(NO_FW);
        if (reg_write_mem && rd_mem == src) return int'(FW_MEM);
        if (reg_write_wb && rd_wb == src) return int'(FW_WB);
        return int'(NO_FW);
    endfunction

    // Expected stall/flush enables from the priority rules and the reference state.
    function automatic void exp_ctl(output bit sf, output bit sd, output bit se,
                                    output bit sm, output bit fd, output bit fe);
        bit lu, hit, full;
        lu   = mem_read_exe && rd_exe != 0 && (rs1_dec == rd_exe || rs2_dec == rd_exe);
        hit  = mbusy[rs1_dec] || mbusy[rs2_dec] || (reg_write_dec && mbusy[rd_dec]);
        full = (mpend == MAX_PENDING);
        sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0;
        if (dmem_wait) begin
            sf = 1; sd = 1; se = 1; sm = 1;
        end else if (took_branch) begin
            fd = 1; fe = 1;
        end else if (lu || hit || (long_dec && full)) begin
            sf = 1; sd = 1; fe = 1;
        end
    endfunction

    // Reference state update on each clock edge or reset.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                foreach (mbusy[i]) mbusy[i] = 1'b0;
                mpend = 0;
                merr  = 1'b0;
                mcnt  = 0;
            end else begin
                bit sf, sd, se, sm, fd, fe, issue;
                exp_ctl(sf, sd, se, sm, fd, fe);
                if (sd && mcnt < CNT_MAX) mcnt++;
                issue = long_issue && long_rd != 0 && !dmem_wait;
                if (issue && mpend == MAX_PENDING) begin
                    merr  = 1'b1;
                    issue = 1'b0;
                end
                if (long_done) begin
                    if (mbusy[long_done_rd]) begin
                        mbusy[long_done_rd] = 1'b0;
                        mpend--;
                    end else begin
                        merr = 1'b1;
                    end
                end
                if (issue) begin
                    mbusy[long_rd] = 1'b1;
                    mpend++;
                end
            end
        end
    end

    // Every-cycle comparison against the reference.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                bit sf, sd, se, sm, fd, fe;
                exp_ctl(sf, sd, se, sm, fd, fe);
                check("fwd_rs1_exe",  fwd_rs1_exe,  fw_exp(rs1_exe));
                check("fwd_rs2_exe",  fwd_rs2_exe,  fw_exp(rs2_exe));
                check("stall_fetch",  stall_fetch,  sf);
                check("stall_dec",    stall_dec,    sd);
                check("stall_exe",    stall_exe,    se);
                check("stall_mem",    stall_mem,    sm);
                check("flush_dec",    flush_dec,    fd);
                check("flush_exe",    flush_exe,    fe);
                check("sb_full",      sb_full,      (mpend == MAX_PENDING) ? 1 : 0);
                check("sb_err",       sb_err,       merr);
                check("stall_cycles", stall_cycles, mcnt);
            end
        end
    end

    task automatic idle();
        rs1_dec = 0; rs2_dec = 0; rd_dec = 0; reg_write_dec = 0; long_dec = 0;
        rs1_exe = 0; rs2_exe = 0; rd_exe = 0; mem_read_exe = 0; took_branch = 0;
        long_issue = 0; long_rd = 0; long_done = 0; long_done_rd = 0;
        rd_mem = 0; rd_wb = 0; reg_write_mem = 0; reg_write_wb = 0; dmem_wait = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #1 rst = 1'b1;
        checking = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_stall_cycles", stall_cycles, 0);
        check("rst_sb_err", sb_err, 0);
        check("rst_sb_full", sb_full, 0);
        check("rst_stall_dec", stall_dec, 0);
        next();
        rst = 1'b0;
        next();

        // Forwarding priority: MEM over WB, x0 never forwarded.
        rs1_exe = 5; rs2_exe = 5; rd_mem = 5; reg_write_mem = 1; rd_wb = 5; reg_write_wb = 1;
        @(negedge clk);
        check("fwd_mem_rs1", fwd_rs1_exe, FW_MEM);
        check("fwd_mem_rs2", fwd_rs2_exe, FW_MEM);
        #1 reg_write_mem = 0;
        #1 check("fwd_wb_rs1", fwd_rs1_exe, FW_WB);
        rs1_exe = 0;
        #1 check("fwd_x0_rs1", fwd_rs1_exe, NO_FW);
        check("fwd_wb_rs2", fwd_rs2_exe, FW_WB);
        next();
        idle();

        // Load-use stall, then the same hazard squashed by a taken branch.
        mem_read_exe = 1; rd_exe = 3; rs2_dec = 3;
        @(negedge clk);
        check("lu_stall_fetch", stall_fetch, 1);
        check("lu_stall_dec", stall_dec, 1);
        check("lu_flush_exe", flush_exe, 1);
        check("lu_stall_exe", stall_exe, 0);
        check("lu_flush_dec", flush_dec, 0);
        next();
        took_branch = 1;
        @(negedge clk);
        check("br_flush_dec", flush_dec, 1);
        check("br_flush_exe", flush_exe, 1);
        check("br_stall_dec", stall_dec, 0);
        check("br_stall_fetch", stall_fetch, 0);
        next();
        idle();
        @(negedge clk);
        check("lu_count", stall_cycles, 1);

        // RAW on a long op: invisible in its issue cycle, held until the cycle after done.
        next();
        long_issue = 1; long_rd = 7; rs1_dec = 7;
        @(negedge clk);
        check("issue_cycle_no_stall", stall_dec, 0);
        next();
        long_issue = 0;
        repeat (3) begin
            @(negedge clk);
            check("raw_stall", stall_dec, 1);
            next();
        end
        long_done = 1; long_done_rd = 7;
        @(negedge clk);
        check("done_cycle_stall", stall_dec, 1);
        next();
        long_done = 0;
        @(negedge clk);
        check("raw_release", stall_dec, 0);
        check("raw_count", stall_cycles, 5);

        // Long stall drives the 4-bit counter into saturation.
        next();
        long_issue = 1; long_rd = 7; rs1_dec = 0;
        next();
        long_issue = 0; rs1_dec = 7;
        repeat (12) next();
        @(negedge clk);
        check("cnt_saturate", stall_cycles, 15);
        next();
        long_done = 1; long_done_rd = 7;
        next();
        idle();

        // Fill the scoreboard, stall a long op in DEC, then free one slot.
        for (int i = 1; i <= 4; i++) begin
            long_issue = 1; long_rd = 5'(i);
            if (i == 4) begin
                @(negedge clk);
                check("not_full_at_3", sb_full, 0);
            end
            next();
        end
        long_issue = 0; long_rd = 0; long_dec = 1;
        @(negedge clk);
        check("full_at_4", sb_full, 1);
        check("full_long_dec_stall", stall_dec, 1);
        next();
        long_done = 1; long_done_rd = 2;
        @(negedge clk);
        check("full_until_edge", sb_full, 1);
        next();
        long_done = 0;
        @(negedge clk);
        check("full_released", sb_full, 0);
        check("long_dec_released", stall_dec, 0);

        // Freeze beats branch; an issue during the freeze is not recorded.
        next();
        idle();
        dmem_wait = 1; took_branch = 1; long_issue = 1; long_rd = 10;
        @(negedge clk);
        check("frz_stall_fetch", stall_fetch, 1);
        check("frz_stall_dec", stall_dec, 1);
        check("frz_stall_exe", stall_exe, 1);
        check("frz_stall_mem", stall_mem, 1);
        check("frz_flush_dec", flush_dec, 0);
        check("frz_flush_exe", flush_exe, 0);
        next();
        dmem_wait = 0; long_issue = 0; long_rd = 0; rs1_dec = 10;
        @(negedge clk);
        check("post_frz_flush_dec", flush_dec, 1);
        check("post_frz_flush_exe", flush_exe, 1);
        next();
        took_branch = 0;
        @(negedge clk);
        check("frz_issue_dropped", stall_dec, 0);

        // Completion of an idle register: sticky error, pending untouched.
        next();
        idle();
        long_done = 1; long_done_rd = 20;
        @(negedge clk);
        check("err_not_yet", sb_err, 0);
        next();
        long_done = 0;
        @(negedge clk);
        check("err_set", sb_err, 1);
        check("err_pending_kept", sb_full, 0);
        next();
        long_issue = 1; long_rd = 5;
        next();
        long_issue = 0;
        @(negedge clk);
        check("refill_full", sb_full, 1);
        // Overflow issue is dropped.
        next();
        long_issue = 1; long_rd = 9;
        next();
        long_issue = 0; rs1_dec = 9;
        @(negedge clk);
        check("overflow_dropped", stall_dec, 0);
        check("err_sticky", sb_err, 1);

        // Same-cycle set and clear of one register keeps it busy.
        next();
        idle();
        long_done = 1; long_done_rd = 1;
        next();
        long_done = 1; long_done_rd = 5; long_issue = 1; long_rd = 5;
        next();
        idle();
        rs1_dec = 5;
        @(negedge clk);
        check("setclr_busy", stall_dec, 1);
        check("setclr_not_full", sb_full, 0);

        // Asynchronous reset in the middle of a cycle.
        next();
        rs1_dec = 3;
        #2 rst = 1'b1;
        #1;
        check("arst_sb_err", sb_err, 0);
        check("arst_stall_cycles", stall_cycles, 0);
        check("arst_sb_full", sb_full, 0);
        check("arst_busy_cleared", stall_dec, 0);
        next();
        rst = 1'b0;
        next();
        @(negedge clk);
        check("post_rst_stall_dec", stall_dec, 0);
        check("post_rst_sb_err", sb_err, 0);
        next();
        checking = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
